sh7604_dbus_arb: RTL

Arbiter that owns the SH7604 data bus (DBUS) and shares it among three requesters: the CPU bus path, the DMAC, and an external bus master. Grants are registered. Ownership changes only at transfer boundaries, and never inside a locked sequence. A bounded-burst counter keeps a long DMAC cycle-steal run from starving the CPU. The arbiter sits between the CPU/DMAC bus-request logic and the BSC.

---
 rtl/sh7604_dbus_arb_if.sv | 26 ++
 rtl/sh7604_dbus_arb.sv | 87 ++++++++
 2 files changed

// File: rtl/sh7604_dbus_arb_if.sv
// DBUS arbitration bundle: requester-side controls in, ownership/grant status out.
// The requester logic uses the master view; the arbiter uses the slave view.
interface sh7604_dbus_arb_if;
    logic       CE;
    logic       CPU_REQ;
    logic       CPU_LOCK;
    logic       DMA_REQ;
    logic       DMA_LOCK;
    logic       EXT_BREQ;
    logic       BUS_WAIT;
    logic       CPU_GNT;
    logic       DMA_GNT;
    logic       EXT_BACK;
    logic [1:0] BUS_OWNER;
    logic       CPU_STALL;

    modport master (
        output CE, CPU_REQ, CPU_LOCK, DMA_REQ, DMA_LOCK, EXT_BREQ, BUS_WAIT,
        input  CPU_GNT, DMA_GNT, EXT_BACK, BUS_OWNER, CPU_STALL
    );

    modport slave (
        input  CE, CPU_REQ, CPU_LOCK, DMA_REQ, DMA_LOCK, EXT_BREQ, BUS_WAIT,
        output CPU_GNT, DMA_GNT, EXT_BACK, BUS_OWNER, CPU_STALL
    );
endinterface

// File: rtl/sh7604_dbus_arb.sv
// SH7604 data-bus arbiter: CPU / DMAC / external master, registered grants,
// ownership changes only at unlocked transfer boundaries, bounded DMAC bursts.
module sh7604_dbus_arb #(
    parameter int MAX_DMA_BURST = 16
) (
    input  logic              CLK,
    input  logic              RST,
    sh7604_dbus_arb_if.slave  bus
);
    localparam int CW = (MAX_DMA_BURST > 0) ? $clog2(MAX_DMA_BURST + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_DMA_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_DMA  = 2'b10,
        S_EXT  = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] dcnt_nxt;
    logic          done_cpu;
    logic          done_dma;
    logic          starve;
    state_t        pick;

    function automatic state_t arb(input logic ebreq, input logic dreq,
                                   input logic creq, input logic stv);
        if (ebreq)
            return S_EXT;
        else if (stv && creq)
            return S_CPU;
        else if (dreq)
            return S_DMA;
        else if (creq)
            return S_CPU;
        else
            return S_IDLE;
    endfunction

    always_comb begin
        done_cpu = (state == S_CPU) && bus.CPU_REQ && !bus.BUS_WAIT;
        done_dma = (state == S_DMA) && bus.DMA_REQ && !bus.BUS_WAIT;

        dcnt_nxt = dcnt;
        if (!bus.CPU_REQ || done_cpu)
            dcnt_nxt = '0;
        else if (done_dma && !bus.DMA_LOCK && dcnt != CMAX)
            dcnt_nxt = dcnt + CW'(1);

        // Judged on the count including the transfer completing now, so the
        // MAX_DMA_BURST-th unlocked DMAC transfer is the one that hands over.
        starve = (MAX_DMA_BURST != 0) && (dcnt_nxt == CMAX);
        pick   = arb(bus.EXT_BREQ, bus.DMA_REQ, bus.CPU_REQ, starve);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = pick;
            S_CPU:  if (!bus.BUS_WAIT && !bus.CPU_LOCK) state_nxt = pick;
            S_DMA:  if (!bus.BUS_WAIT && !bus.DMA_LOCK) state_nxt = pick;
            // Leaving EXT always passes through IDLE for bus turnaround.
            S_EXT:  if (!bus.EXT_BREQ) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            dcnt  <= '0;
        end else if (bus.CE) begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    assign bus.CPU_GNT   = (state == S_CPU);
    assign bus.DMA_GNT   = (state == S_DMA);
    assign bus.EXT_BACK  = (state == S_EXT);
    assign bus.BUS_OWNER = state;
    assign bus.CPU_STALL = bus.CPU_REQ && (state != S_CPU);

endmodule
